// File: rtl/pong_video_pkg.sv
// Shared geometry defaults, FSM encoding and the signature fold for the pong video receiver.
package pong_video_pkg;

  localparam int TABLE_WIDTH_DEF  = 128;
  localparam int TABLE_HEIGHT_DEF = 64;
  localparam int X_BIT_WIDTH_DEF  = 9;
  localparam int Y_BIT_WIDTH_DEF  = 8;
  localparam int ERR_CNT_W_DEF    = 8;
  localparam int SIG_W            = 16;
  localparam int RGB_W            = 12;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Rotate left by one, then add the zero-extended colour (wraps mod 2^SIG_W).
  function automatic logic [SIG_W-1:0] sig_fold(input logic [SIG_W-1:0] s,
                                                input logic [RGB_W-1:0] rgb);
    return {s[SIG_W-2:0], s[SIG_W-1]} + {{(SIG_W-RGB_W){1'b0}}, rgb};
  endfunction

endpackage

// File: rtl/pong_frame_sig.sv
// Rotate-add frame signature accumulator; clr restarts the running value, latch publishes it.
// Latency 1 clk; no backpressure (updates whenever the controls say so).
module pong_frame_sig
  import pong_video_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             latch,
  input  logic [RGB_W-1:0] dat,
  output logic [SIG_W-1:0] frame_sig
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] frame_sig_q, frame_sig_d;
  logic [SIG_W-1:0] base;

  // latch reads the old running value, so a same-edge clr+en starts the next frame cleanly.
  always_comb begin
    frame_sig_d = latch ? sig_q : frame_sig_q;
    base        = clr ? '0 : sig_q;
    sig_d       = en ? sig_fold(base, dat) : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q       <= '0;
      frame_sig_q <= '0;
    end else begin
      sig_q       <= sig_d;
      frame_sig_q <= frame_sig_d;
    end
  end

  assign frame_sig = frame_sig_q;

endmodule

// File: rtl/pong_video_rx.sv
// Video sink: recovers x/y from hsync/vsync, locks to frame timing, emits active pixels and a frame signature.
// Latency 1 clk from the p_tick sample edge; no backpressure, the source is never stalled.
module pong_video_rx
  import pong_video_pkg::*;
#(
  parameter int TABLE_WIDTH   = TABLE_WIDTH_DEF,
  parameter int TABLE_HEIGHT  = TABLE_HEIGHT_DEF,
  parameter int SCREEN_WIDTH  = TABLE_WIDTH + 10,
  parameter int SCREEN_HEIGHT = TABLE_HEIGHT + 10,
  parameter int X_BIT_WIDTH   = X_BIT_WIDTH_DEF,
  parameter int Y_BIT_WIDTH   = Y_BIT_WIDTH_DEF,
  parameter int ERR_CNT_W     = ERR_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_tick,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [11:0]            rgb,
  output logic                   locked,
  output logic                   pix_valid,
  output logic [X_BIT_WIDTH-1:0] pix_x,
  output logic [Y_BIT_WIDTH-1:0] pix_y,
  output logic [11:0]            pix_rgb,
  output logic                   frame_done,
  output logic [15:0]            frame_sig,
  output logic                   sync_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam logic [X_BIT_WIDTH-1:0] SW_X = X_BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [X_BIT_WIDTH-1:0] TW_X = X_BIT_WIDTH'(TABLE_WIDTH);
  localparam logic [Y_BIT_WIDTH-1:0] SH_Y = Y_BIT_WIDTH'(SCREEN_HEIGHT);
  localparam logic [Y_BIT_WIDTH-1:0] TH_Y = Y_BIT_WIDTH'(TABLE_HEIGHT);

  logic [1:0]             state_q, state_d;
  logic [X_BIT_WIDTH-1:0] x_q, x_d, cur_x, pix_x_q, pix_x_d;
  logic [Y_BIT_WIDTH-1:0] y_q, y_d, cur_y, pix_y_q, pix_y_d;
  logic                   vs_prev_q, vs_prev_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [11:0]            pix_rgb_q, pix_rgb_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   frame_start, mismatch, active;
  logic                   sig_clr, sig_en, sig_latch;

  // x_q/y_q hold the position of the last accepted sample; cur_* is where this sample should be.
  always_comb begin
    cur_x = (x_q == SW_X) ? '0 : x_q + X_BIT_WIDTH'(1);
    cur_y = y_q;
    if (x_q == SW_X) cur_y = (y_q == SH_Y) ? '0 : y_q + Y_BIT_WIDTH'(1);
    frame_start = vs_prev_q && !vsync;
    mismatch    = (hsync != (cur_x == SW_X)) || (vsync != (cur_y == SH_Y));
    active      = (cur_x <= TW_X) && (cur_y <= TH_Y);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vs_prev_d    = vs_prev_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    err_cnt_d    = err_cnt_q;
    sig_clr      = 1'b0;
    sig_en       = 1'b0;
    sig_latch    = 1'b0;
    if (p_tick) begin
      vs_prev_d = vsync;
      if (state_q == ST_SEARCH) begin
        if (frame_start) begin
          state_d = ST_ALIGN;
          x_d     = '0;
          y_d     = '0;
        end
      end else if (mismatch) begin
        sync_err_d = 1'b1;
        state_d    = ST_SEARCH;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        x_d = cur_x;
        y_d = cur_y;
        // Lock entry starts a fresh signature with pixel (0,0) already in it, so the
        // first locked frame is comparable with every later one; it just publishes nothing.
        if (frame_start) begin
          sig_clr      = 1'b1;
          sig_latch    = (state_q == ST_LOCKED);
          frame_done_d = (state_q == ST_LOCKED);
          state_d      = ST_LOCKED;
        end
        if ((state_d == ST_LOCKED) && active) begin
          pix_valid_d = 1'b1;
          pix_x_d     = cur_x;
          pix_y_d     = cur_y;
          pix_rgb_d   = rgb;
          sig_en      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SEARCH;
      x_q          <= '0;
      y_q          <= '0;
      vs_prev_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vs_prev_q    <= vs_prev_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  pong_frame_sig u_frame_sig (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (sig_clr),
    .en        (sig_en),
    .latch     (sig_latch),
    .dat       (rgb),
    .frame_sig (frame_sig)
  );

  assign locked     = (state_q == ST_LOCKED);
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pong_video_rx.sv
// Bench for pong_video_rx: raster source, queue scoreboard with due-cycle tags, directed lock/error/reset checks.
module tb_pong_video_rx;

  localparam int SW = 138;
  localparam int SH = 74;
  localparam int TW = 128;
  localparam int TH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, hsync, vsync;
  logic [11:0] rgb;
  logic        locked, pix_valid, frame_done, sync_err;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [11:0] pix_rgb;
  logic [15:0] frame_sig;
  logic [7:0]  err_cnt;

  pong_video_rx dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_sig  (frame_sig),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int x; int y; logic [11:0] c; } pix_exp_t;
  typedef struct { int due; logic [15:0] sig; } frm_exp_t;
  typedef struct { int due; int cnt; } err_exp_t;

  pix_exp_t pix_q[$];
  frm_exp_t frm_q[$];
  err_exp_t err_q[$];
  pix_exp_t pe;
  frm_exp_t fe;
  err_exp_t ee;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pix_cnt = 0;
  int last_pix_cnt = 0;

  // Receiver model (0 search, 1 align, 2 locked) and raster source position.
  int          m_st, m_x, m_y, m_err;
  logic        m_vprev;
  logic [15:0] m_sig;
  int          gx, gy;
  bit          pat;
  logic [15:0] exp_fff;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fff_sig();
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < 129 * 65; i++) s = {s[14:0], s[15]} + 16'h0FFF;
    return s;
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({locked, pix_valid, pix_x, pix_y, pix_rgb, frame_done, frame_sig, sync_err, err_cnt});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 0; m_y = 0; m_err = 0; m_vprev = 1'b0; m_sig = 16'h0;
  endtask

  // One p_tick sample; expectations are pushed tagged with the cycle they must appear in.
  task automatic send(input logic hs, input logic vs, input logic [11:0] c);
    bit fs;
    int nx, ny;
    p_tick = 1'b1; hsync = hs; vsync = vs; rgb = c;
    fs = !vs && m_vprev;
    m_vprev = vs;
    if (m_st == 0) begin
      if (fs) begin m_st = 1; m_x = 0; m_y = 0; end
    end else begin
      nx = (m_x == SW) ? 0 : m_x + 1;
      ny = (m_x != SW) ? m_y : ((m_y == SH) ? 0 : m_y + 1);
      if ((hs != (nx == SW)) || (vs != (ny == SH))) begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_st = 0;
        err_q.push_back('{cyc + 1, m_err});
      end else begin
        m_x = nx; m_y = ny;
        if (fs) begin
          if (m_st == 2) frm_q.push_back('{cyc + 1, m_sig});
          m_sig = 16'h0;
          m_st = 2;
        end
        if (m_st == 2 && nx <= TW && ny <= TH) begin
          pix_q.push_back('{cyc + 1, nx, ny, c});
          m_sig = {m_sig[14:0], m_sig[15]} + {4'h0, c};
        end
      end
    end
    @(posedge clk);
    #1;
    p_tick = 1'b0;
  endtask

  task automatic gen_one(input logic force_hs);
    logic [11:0] c;
    c = pat ? {gx[3:0], gy[3:0], gx[7:4]} : 12'hFFF;
    send((gx == SW) || force_hs, gy == SH, c);
    if (gx == SW) begin
      gx = 0;
      gy = (gy == SH) ? 0 : gy + 1;
    end else begin
      gx = gx + 1;
    end
  endtask

  task automatic gen_until(input int x, input int y);
    while (!(gx == x && gy == y)) gen_one(1'b0);
  endtask

  // Monitor: pops an expectation whenever the DUT pulses; stale entries are missed pulses.
  initial begin
    forever begin
      @(negedge clk);
      while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
        pe = pix_q.pop_front(); checks++; errors++;
        $display("FAIL pix_missing: got no pix_valid at cycle %0d, expected (%0d,%0d)", pe.due, pe.x, pe.y);
      end
      while (frm_q.size() > 0 && frm_q[0].due < cyc) begin
        fe = frm_q.pop_front(); checks++; errors++;
        $display("FAIL frame_missing: got no frame_done at cycle %0d, expected sig %04h", fe.due, fe.sig);
      end
      while (err_q.size() > 0 && err_q[0].due < cyc) begin
        ee = err_q.pop_front(); checks++; errors++;
        $display("FAIL err_missing: got no sync_err at cycle %0d, expected err_cnt %0d", ee.due, ee.cnt);
      end
      if (pix_valid) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected: got (%0d,%0d) at cycle %0d, expected no pixel", pix_x, pix_y, cyc);
        end else begin
          pe = pix_q.pop_front();
          if (pe.due != cyc || pix_x != 9'(pe.x) || pix_y != 8'(pe.y) || pix_rgb != pe.c) begin
            errors++;
            $display("FAIL pix: got (%0d,%0d) rgb %03h cycle %0d, expected (%0d,%0d) rgb %03h cycle %0d",
                     pix_x, pix_y, pix_rgb, cyc, pe.x, pe.y, pe.c, pe.due);
          end
        end
      end
      if (frame_done) begin
        checks++;
        if (frm_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got frame_done sig %04h at cycle %0d, expected none", frame_sig, cyc);
        end else begin
          fe = frm_q.pop_front();
          if (fe.due != cyc || frame_sig != fe.sig) begin
            errors++;
            $display("FAIL frame: got sig %04h cycle %0d, expected sig %04h cycle %0d", frame_sig, cyc, fe.sig, fe.due);
          end
        end
        last_pix_cnt = pix_cnt;
        pix_cnt = 0;
      end
      if (pix_valid) pix_cnt++;
      if (sync_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got sync_err at cycle %0d, expected none", cyc);
        end else begin
          ee = err_q.pop_front();
          if (ee.due != cyc || err_cnt != 8'(ee.cnt)) begin
            errors++;
            $display("FAIL err: got err_cnt %0d cycle %0d, expected err_cnt %0d cycle %0d", err_cnt, cyc, ee.cnt, ee.due);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 12'h0;
    model_reset();
    gx = 0; gy = 60; pat = 1'b0;
    exp_fff = fff_sig();
    repeat (3) @(posedge clk);
    settle();
    chk("reset_outputs", all_out(), 64'd0);
    reset = 1'b1;

    // Lock: partial frame, first frame start aligns, second locks.
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("align_not_locked", 64'(locked), 64'd0);
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("locked_second_fs", 64'(locked), 64'd1);
    chk("first_pix_00", 64'({pix_valid, pix_x, pix_y}), 64'({1'b1, 9'd0, 8'd0}));
    chk("no_done_on_lock", 64'(frame_done), 64'd0);

    // Two constant-colour frames: count, last-pixel hold, signature stable.
    for (int f = 0; f < 2; f++) begin
      gen_until(0, 0);
      settle();
      chk("last_pix_hold", 64'({pix_valid, pix_x, pix_y}), 64'({1'b0, 9'd128, 8'd64}));
      gen_one(1'b0);
      settle();
      chk("frame_done_pulse", 64'(frame_done), 64'd1);
      chk("frame_sig_fff", 64'(frame_sig), 64'(exp_fff));
      chk("pix_per_frame", 64'(last_pix_cnt), 64'd8385);
    end

    // p_tick gaps hold state; then hsync one pixel early.
    pat = 1'b1;
    gen_until(0, 2);
    repeat (5) @(posedge clk);
    settle();
    chk("idle_hold", 64'({locked, pix_valid, pix_x, pix_y}), 64'({1'b1, 1'b0, 9'd138 - 9'd10, 8'd1}));
    gen_until(137, 10); gen_one(1'b1);
    settle();
    chk("early_hsync_err", 64'({sync_err, err_cnt, locked}), 64'({1'b1, 8'd1, 1'b0}));
    settle();
    chk("err_pulse_1clk", 64'(sync_err), 64'd0);
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("realign_not_locked", 64'(locked), 64'd0);
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("relocked", 64'({locked, frame_done}), 64'({1'b1, 1'b0}));
    chk("sig_kept_after_err", 64'(frame_sig), 64'(exp_fff));

    // Reset mid-frame at y=30 for 3 clocks.
    gen_until(0, 30);
    settle();
    reset = 1'b0;
    model_reset();
    #1;
    chk("reset_immediate", all_out(), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", all_out(), 64'd0);
    end
    #1 reset = 1'b1;
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("post_reset_align", 64'(locked), 64'd0);
    gen_until(0, 0); gen_one(1'b0);
    settle();
    chk("post_reset_lock", 64'({locked, frame_sig, err_cnt}), 64'({1'b1, 16'h0, 8'd0}));

    // Forced mismatches: the first pass errors twice (locked vsync, then early hsync).
    gen_until(0, 3);
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 1'b1, 12'h0);
      send(1'b0, 1'b0, 12'h0);
      send(1'b1, 1'b0, 12'h0);
      settle();
      chk("err_cnt_sat", 64'(err_cnt), 64'((i + 2 > 255) ? 255 : i + 2));
    end
    chk("err_final", 64'({err_cnt, locked}), 64'({8'd255, 1'b0}));

    repeat (3) settle();
    chk("scoreboard_drained", 64'(pix_q.size() + frm_q.size() + err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
